// File: rtl/seq_detect_param.sv
// Serial sequence detector: finds a loadable SEQ_LEN-bit pattern in a qualified 1-bit stream,
// with overlap control and a saturating match counter. Optional SEQ_DETECT_MASK_EN adds a don't-care mask.
module seq_detect_param #(
  parameter int                 SEQ_LEN     = 4,
  parameter logic [SEQ_LEN-1:0] SEQ_DEFAULT = 4'b1011,
  parameter int                 CNT_W       = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inp_bit,
  input  logic               in_valid,
  input  logic [SEQ_LEN-1:0] pattern_in,
  input  logic               pattern_load,
  input  logic               overlap_en,
  input  logic               count_clr,
`ifdef SEQ_DETECT_MASK_EN
  input  logic [SEQ_LEN-1:0] mask_in,
`endif
  output logic               seq_seen,
  output logic [CNT_W-1:0]   match_count
);

  localparam int                FILL_W = $clog2(SEQ_LEN + 1);
  localparam logic [FILL_W-1:0] FULL   = FILL_W'(SEQ_LEN);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  logic [SEQ_LEN-1:0] pattern_q;
  logic [SEQ_LEN-1:0] hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic               seen_q;
  logic [CNT_W-1:0]   count_q;
  logic               cmp_hit;
  logic               match;

`ifdef SEQ_DETECT_MASK_EN
  logic [SEQ_LEN-1:0] mask_q;

  // Cleared mask bits are don't-care positions.
  assign cmp_hit = ((hist_d ^ pattern_q) & mask_q) == '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q <= '1;
    end else if (pattern_load) begin
      mask_q <= mask_in;
    end
  end
`else
  assign cmp_hit = (hist_d == pattern_q);
`endif

  always_comb begin
    hist_d = {hist_q[SEQ_LEN-2:0], inp_bit};
    fill_d = (fill_q == FULL) ? fill_q : fill_q + 1'b1;
    match  = in_valid && !pattern_load && (fill_d == FULL) && cmp_hit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pattern_q <= SEQ_DEFAULT;
      hist_q    <= '0;
      fill_q    <= '0;
      seen_q    <= 1'b0;
    end else if (pattern_load) begin
      pattern_q <= pattern_in;
      hist_q    <= '0;
      fill_q    <= '0;
      seen_q    <= 1'b0;
    end else if (in_valid) begin
      hist_q <= hist_d;
      // Non-overlapping mode demands a full set of fresh bits after each hit.
      fill_q <= (match && !overlap_en) ? '0 : fill_d;
      seen_q <= match;
    end else begin
      seen_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || count_clr) begin
      count_q <= '0;
    end else if (match && (count_q != CNT_MAX)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign seq_seen    = seen_q;
  assign match_count = count_q;

endmodule
